cache_refill_unit: RTL
======================

CACHE_REFILL_UNIT -- requirements
Module: cache_refill_unit

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 3, tag width in bits.
REQ-002 SHALL have parameter INDEX_WIDTH, default 5, cache line index width in bits.
REQ-003 SHALL have parameter BLOCK_WIDTH, default 2, word-in-line width in bits; BLOCKS = 2**BLOCK_WIDTH.
REQ-004 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 15, maximum wait cycles for i_mem_ack.
REQ-006 SHALL have port i_clock  input  1  clock; all state changes on its rising edge.
REQ-007 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port i_start  input  1  line refill request.
REQ-009 SHALL have ports i_tag / i_index / i_block  input  TAG_WIDTH / INDEX_WIDTH / BLOCK_WIDTH  line address and critical (first) word.
REQ-010 SHALL have port o_mem_rd  output  1  memory read request.
REQ-011 SHALL have port o_mem_addr  output  TAG_WIDTH+INDEX_WIDTH+BLOCK_WIDTH  word address {tag,index,block}.
REQ-012 SHALL have ports i_mem_data  input  DATA_WIDTH  read data; i_mem_ack  input  1  data valid.
REQ-013 SHALL have ports o_tag / o_index / o_block  output  TAG/INDEX/BLOCK widths  cache write address.
REQ-014 SHALL have ports o_data  output  DATA_WIDTH  cache write data; o_wr  output  1  cache write enable.
REQ-015 SHALL have ports o_busy, o_done, o_error  output  1 each  refill active / completion pulse / timeout pulse.

Function
REQ-016 SHALL implement states IDLE, READ, WRITE.
REQ-017 IDLE: o_busy=0, o_mem_rd=0, o_wr=0; on i_start=1 latch i_tag, i_index, i_block (also as start block), go READ next cycle.
REQ-018 READ: o_busy=1, o_mem_rd=1, o_mem_addr={tag,index,block} held stable until ack; on i_mem_ack=1 capture i_mem_data, go WRITE.
REQ-019 WRITE: o_wr=1 for exactly one cycle, o_tag/o_index/o_block = latched address, o_data = captured word; block <= block+1 modulo BLOCKS.
REQ-020 After WRITE, if incremented block equals start block: o_done=1 in that WRITE cycle, go IDLE; else go READ.
REQ-021 Word order SHALL be start block first, wrap-around: i_block=2, BLOCKS=4 -> 2,3,0,1.
REQ-022 Minimum latency: 2 cycles per word; refill with zero-wait ack completes 1+2*BLOCKS cycles after i_start.
REQ-023 i_start while o_busy=1 SHALL be ignored; i_start in the WRITE cycle carrying o_done SHALL also be ignored.
REQ-024 i_mem_ack outside READ SHALL be ignored; i_mem_data not sampled outside READ.
REQ-025 o_mem_addr, o_tag, o_index, o_block SHALL reflect latched registers in every state.

Reset
REQ-026 i_reset=1 SHALL force IDLE and clear tag, index, block, start block, data register, timeout counter to 0 at next edge.
REQ-027 After reset, outputs: o_mem_rd=0, o_wr=0, o_busy=0, o_done=0, o_error=0, o_data=0, o_mem_addr=0, o_tag/o_index/o_block=0.
REQ-028 Reset mid-refill SHALL abort with no further o_wr and no o_done; i_reset has priority over i_start and i_mem_ack.

Configuration
REQ-029 Macro CACHE_REFILL_TIMEOUT_EN defined: counter clears on READ entry, increments each READ cycle without ack; at TIMEOUT_CYCLES waits -> o_mem_rd drops, o_error=1 one cycle, go IDLE, no o_wr, no o_done.
REQ-030 Macro undefined: READ waits indefinitely, o_error tied 0, TIMEOUT_CYCLES unused, no counter logic.

Verification
REQ-031 Reset then i_start, tag=5, index=17, block=0, ack every READ cycle -> o_wr blocks 0,1,2,3, o_done at cycle 9, o_busy low cycle 10.
REQ-032 i_start block=3 -> o_mem_addr low bits 3,0,1,2; o_data equals supplied words in that order.
REQ-033 Ack delayed 4 cycles per word -> o_mem_rd and o_mem_addr stable across wait; one o_wr per word.
REQ-034 i_start pulsed during refill with tag=1 -> ignored; all four writes keep original tag.
REQ-035 i_reset asserted after second o_wr -> next cycle o_busy=0, o_mem_rd=0, no o_done, no further o_wr.
REQ-036 With CACHE_REFILL_TIMEOUT_EN, no ack -> o_error pulse after 15 wait cycles, IDLE, o_wr never asserted; without macro o_mem_rd stays 1.

Source files
------------

// File: rtl/cache_refill_unit.sv
// Cache line refill: fetches all words of one line from memory, critical word first, wrap-around order.
// Latency: 1 cycle from i_start to the first read; then 2 cycles per word with zero-wait ack.
// Backpressure: READ holds o_mem_rd/o_mem_addr until i_mem_ack; i_start is ignored while busy.
// Optional: define CACHE_REFILL_TIMEOUT_EN to abort a read after TIMEOUT_CYCLES waits (o_error pulse).
module cache_refill_unit #(
  parameter int TAG_WIDTH      = 3,
  parameter int INDEX_WIDTH    = 5,
  parameter int BLOCK_WIDTH    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                                     i_clock,
  input  logic                                     i_reset,
  input  logic                                     i_start,
  input  logic [TAG_WIDTH-1:0]                     i_tag,
  input  logic [INDEX_WIDTH-1:0]                   i_index,
  input  logic [BLOCK_WIDTH-1:0]                   i_block,
  output logic                                     o_mem_rd,
  output logic [TAG_WIDTH+INDEX_WIDTH+BLOCK_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0]                    i_mem_data,
  input  logic                                     i_mem_ack,
  output logic [TAG_WIDTH-1:0]                     o_tag,
  output logic [INDEX_WIDTH-1:0]                   o_index,
  output logic [BLOCK_WIDTH-1:0]                   o_block,
  output logic [DATA_WIDTH-1:0]                    o_data,
  output logic                                     o_wr,
  output logic                                     o_busy,
  output logic                                     o_done,
  output logic                                     o_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [TAG_WIDTH-1:0]   r_tag;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [BLOCK_WIDTH-1:0] r_block;
  logic [BLOCK_WIDTH-1:0] r_start_block;
  logic [DATA_WIDTH-1:0]  r_data;

  logic [BLOCK_WIDTH-1:0] w_block_inc;
  logic                   w_line_done;
  logic                   w_timed_out;
  logic                   w_capture;

  // Next word index wraps naturally modulo the number of words per line.
  assign w_block_inc = BLOCK_WIDTH'(r_block + 1'b1);
  // Line is complete once the incremented index comes back around to the critical word.
  assign w_line_done = (w_block_inc == r_start_block);

`ifdef CACHE_REFILL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_timeout;

  // The cycle after TIMEOUT_CYCLES unacknowledged waits is the abort cycle.
  assign w_timed_out = (r_state == ST_READ) && (r_timeout == TW'(TIMEOUT_CYCLES));

  // Wait counter: zero outside READ so every READ entry starts fresh; counts unacked READ cycles.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_timeout <= '0;
    end else if (r_state != ST_READ) begin
      r_timeout <= '0;
    end else if (!i_mem_ack && !w_timed_out) begin
      r_timeout <= r_timeout + 1'b1;
    end
  end
`else
  // Without the timeout feature a read waits forever for its ack.
  assign w_timed_out = 1'b0;
  logic w_unused_timeout_param;
  assign w_unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

  // Data is only taken from memory on a real ack inside READ.
  assign w_capture = (r_state == ST_READ) && i_mem_ack && !w_timed_out;

  // State register; reset wins over any request or ack.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_mem_rd     = 1'b0;
    o_wr         = 1'b0;
    o_done       = 1'b0;
    o_error      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = ST_READ;
        end
      end
      ST_READ: begin
        o_busy   = 1'b1;
        o_mem_rd = !w_timed_out;
        o_error  = w_timed_out;
        if (w_timed_out) begin
          w_next_state = ST_IDLE;
        end else if (i_mem_ack) begin
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        o_busy = 1'b1;
        o_wr   = 1'b1;
        o_done = w_line_done;
        w_next_state = w_line_done ? ST_IDLE : ST_READ;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Address and data registers: latch on accepted start, capture on ack, advance after each write.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tag         <= '0;
      r_index       <= '0;
      r_block       <= '0;
      r_start_block <= '0;
      r_data        <= '0;
    end else begin
      if (r_state == ST_IDLE && i_start) begin
        r_tag         <= i_tag;
        r_index       <= i_index;
        r_block       <= i_block;
        r_start_block <= i_block;
      end
      if (w_capture) begin
        r_data <= i_mem_data;
      end
      if (r_state == ST_WRITE) begin
        r_block <= w_block_inc;
      end
    end
  end

  // Addresses always mirror the latched registers, whatever the state.
  assign o_mem_addr = {r_tag, r_index, r_block};
  assign o_tag      = r_tag;
  assign o_index    = r_index;
  assign o_block    = r_block;
  assign o_data     = r_data;

endmodule
